// File: rtl/lsu_bus_bridge.sv
// Byte-addressed load/store to word-bus bridge for the on-chip RAM.
// Forms byte masks/lanes, splits word-crossing accesses, extends load data.

module lsu_bus_bridge_lane #(
    parameter int LANE  = 0,
    parameter int VEC_W = 8
) (
    input  logic [1:0]         off,
    input  logic [2:0]         nbytes,
    input  logic [4*VEC_W-1:0] data,
    output logic               m,
    output logic [VEC_W-1:0]   d
);
    // k is the request byte that lands on this lane of the 8-lane {word1, word0} window
    logic [3:0] k;
    logic       in_win;

    assign k      = 4'(LANE) - {2'b00, off};
    assign in_win = (4'(LANE) >= {2'b00, off}) && (k < 4'd4);
    assign m      = in_win && (k < {1'b0, nbytes});
    assign d      = in_win ? data[k[1:0]*VEC_W +: VEC_W] : '0;
endmodule

module lsu_bus_bridge #(
    parameter bit ALLOW_SPLIT = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_data,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_error,
    output logic [29:0] bus_addr,
    input  logic [31:0] bus_data_r,
    output logic [31:0] bus_data_w,
    output logic [3:0]  bus_mask_w
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC0 = 2'd1;
    localparam logic [1:0] S_ACC1 = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] data;
    } req_t;

    logic [1:0]  state;
    req_t        req_in, req_q, cur;
    logic [31:0] word0_q;

    logic [1:0]  off;
    logic [2:0]  nbytes;
    logic        split;
    logic [29:0] w0, w1;
    logic        accept;

    logic [2*NUM_LANES-1:0]            m8;
    logic [2*NUM_LANES-1:0][VEC_W-1:0] d64;

    logic [31:0] lo, hi, sh, ld_res;

    always_comb begin
        req_in.write = req_write;
        req_in.addr  = req_addr;
        req_in.size  = req_size;
        req_in.sgn   = req_signed;
        req_in.data  = req_data;
    end

    // Lane formation runs off the live request in IDLE (to register ACC0 outputs
    // at accept) and off the latched request afterwards.
    assign cur    = (state == S_IDLE) ? req_in : req_q;
    assign off    = cur.addr[1:0];
    assign accept = req_valid & req_ready;
    assign w0     = cur.addr[31:2];
    assign w1     = w0 + 30'd1;

    always_comb begin
        case (cur.size)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    assign split = ({1'b0, off} + nbytes) > 3'd4;

    for (genvar i = 0; i < 2*NUM_LANES; i++) begin : g_lane
        lsu_bus_bridge_lane #(.LANE(i), .VEC_W(VEC_W)) u_lane (
            .off    (off),
            .nbytes (nbytes),
            .data   (cur.data),
            .m      (m8[i]),
            .d      (d64[i])
        );
    end

    // In WAIT the last read word is on bus_data_r; for split loads word0 was captured in ACC1.
    always_comb begin
        lo = split ? word0_q : bus_data_r;
        hi = split ? bus_data_r : 32'd0;
        sh = 32'({hi, lo} >> {off, 3'b000});
        case (nbytes)
            3'd1:    ld_res = {{24{cur.sgn & sh[7]}}, sh[7:0]};
            3'd2:    ld_res = {{16{cur.sgn & sh[15]}}, sh[15:0]};
            default: ld_res = sh;
        endcase
    end

    assign req_ready = (state == S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            req_q      <= '0;
            word0_q    <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_error <= 1'b0;
            bus_addr   <= '0;
            bus_data_w <= '0;
            bus_mask_w <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            bus_mask_w <= '0;
            case (state)
                S_IDLE: if (accept) begin
                    req_q <= req_in;
                    if (split && !ALLOW_SPLIT) begin
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                        resp_data  <= '0;
                    end else begin
                        state      <= S_ACC0;
                        bus_addr   <= w0;
                        bus_data_w <= d64[NUM_LANES-1:0];
                        bus_mask_w <= req_write ? m8[NUM_LANES-1:0] : 4'h0;
                    end
                end
                S_ACC0: begin
                    if (split) begin
                        state      <= S_ACC1;
                        bus_addr   <= w1;
                        bus_data_w <= d64[2*NUM_LANES-1:NUM_LANES];
                        bus_mask_w <= cur.write ? m8[2*NUM_LANES-1:NUM_LANES] : 4'h0;
                    end else if (!cur.write) begin
                        state <= S_WAIT;
                    end else begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b1;
                        resp_data  <= '0;
                    end
                end
                S_ACC1: begin
                    word0_q <= bus_data_r;
                    if (cur.write) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b1;
                        resp_data  <= '0;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    resp_valid <= 1'b1;
                    resp_data  <= ld_res;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Bench for lsu_bus_bridge: word RAM model on the bus, byte-level reference memory,
// directed cases plus randomized loads/stores, and an ALLOW_SPLIT=0 instance.

module tb_lsu_bus_bridge;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    always #5 clock = ~clock;

    logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
    logic [31:0] req_addr = '0, req_data = '0;
    logic [1:0]  req_size = '0;
    logic        req_ready, resp_valid, resp_error;
    logic [31:0] resp_data, bus_data_r, bus_data_w;
    logic [29:0] bus_addr;
    logic [3:0]  bus_mask_w;

    logic        n_req_valid = 1'b0, n_req_write = 1'b0, n_req_signed = 1'b0;
    logic [31:0] n_req_addr = '0, n_req_data = '0;
    logic [1:0]  n_req_size = '0;
    logic        n_req_ready, n_resp_valid, n_resp_error;
    logic [31:0] n_resp_data, n_bus_data_w;
    logic [31:0] n_bus_data_r = '0;
    logic [29:0] n_bus_addr;
    logic [3:0]  n_bus_mask_w;

    lsu_bus_bridge #(.ALLOW_SPLIT(1'b1)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
        .req_signed(req_signed), .req_data(req_data), .resp_valid(resp_valid),
        .resp_data(resp_data), .resp_error(resp_error), .bus_addr(bus_addr),
        .bus_data_r(bus_data_r), .bus_data_w(bus_data_w), .bus_mask_w(bus_mask_w)
    );

    lsu_bus_bridge #(.ALLOW_SPLIT(1'b0)) dut_ns (
        .clock(clock), .reset(reset), .req_valid(n_req_valid), .req_ready(n_req_ready),
        .req_write(n_req_write), .req_addr(n_req_addr), .req_size(n_req_size),
        .req_signed(n_req_signed), .req_data(n_req_data), .resp_valid(n_resp_valid),
        .resp_data(n_resp_data), .resp_error(n_resp_error), .bus_addr(n_bus_addr),
        .bus_data_r(n_bus_data_r), .bus_data_w(n_bus_data_w), .bus_mask_w(n_bus_mask_w)
    );

    // Word RAM; index bits [6:0] are unique across the address windows used here.
    logic [31:0] ram [128] = '{default: 32'd0};

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clock) begin
        if (bus_mask_w != 4'h0) begin
            ram[bus_addr[6:0]] <= merge(ram[bus_addr[6:0]], bus_data_w, bus_mask_w);
            bus_data_r         <= $urandom;
        end else begin
            bus_data_r <= ram[bus_addr[6:0]];
        end
    end

    // Reference: flat byte-addressed memory.
    bit [7:0] mb [bit [31:0]];

    function automatic bit [7:0] mrd(input bit [31:0] a);
        return mb.exists(a) ? mb[a] : 8'h00;
    endfunction

    int errs = 0, checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [29:0] c_a1, c_a2;
    logic [3:0]  c_m1, c_m2;
    logic [31:0] c_d1, c_d2, c_rd;

    // Issue one request starting at a negedge; returns at the negedge showing resp_valid.
    task automatic op(input bit wr, input bit [31:0] a, input bit [1:0] sz, input bit sg,
                      input bit [31:0] d);
        int n, lat, guard;
        bit sp, got;
        bit [31:0] exp_v;
        n  = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        sp = (int'(a[1:0]) + n) > 4;
        guard = 0;
        while (!req_ready && guard < 20) begin @(negedge clock); guard++; end
        chk("ready", req_ready, 1);
        req_valid = 1; req_write = wr; req_addr = a; req_size = sz; req_signed = sg; req_data = d;
        @(posedge clock);
        lat = 0; got = 0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clock);
            if (k == 1) begin req_valid = 0; c_a1 = bus_addr; c_m1 = bus_mask_w; c_d1 = bus_data_w; end
            if (k == 2) begin c_a2 = bus_addr; c_m2 = bus_mask_w; c_d2 = bus_data_w; end
            if (resp_valid) begin got = 1; lat = k; c_rd = resp_data; chk("err", resp_error, 0); end
        end
        chk(wr ? "st_lat" : "ld_lat", lat, wr ? (sp ? 3 : 2) : (sp ? 4 : 3));
        if (wr) begin
            for (int i = 0; i < n; i++) mb[a + 32'(i)] = d[8*i +: 8];
            chk("st_data", c_rd, 0);
        end else begin
            exp_v = 0;
            for (int i = 0; i < n; i++) exp_v[8*i +: 8] = mrd(a + 32'(i));
            if (sg && n == 1) exp_v = {{24{exp_v[7]}}, exp_v[7:0]};
            if (sg && n == 2) exp_v = {{16{exp_v[15]}}, exp_v[15:0]};
            chk("ld_data", c_rd, exp_v);
        end
    endtask

    initial begin
        bit [31:0] a;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", req_ready, 1);
        chk("rst_rvalid", resp_valid, 0);
        chk("rst_rdata", resp_data, 0);
        chk("rst_rerr", resp_error, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_data_w, 0);
        chk("rst_mask", bus_mask_w, 0);
        reset = 0;
        @(negedge clock);

        op(1, 32'h100, 2, 0, 32'hDEADBEEF);
        chk("w_addr", c_a1, 30'h40); chk("w_mask", c_m1, 4'hF); chk("w_data", c_d1, 32'hDEADBEEF);
        op(1, 32'h103, 0, 0, 32'h80);
        chk("b_mask", c_m1, 4'h8); chk("b_lane", c_d1[31:24], 8'h80);
        op(0, 32'h103, 0, 1, 0);
        chk("lb_s", c_rd, 32'hFFFFFF80);
        op(0, 32'h103, 0, 0, 0);
        chk("lb_u", c_rd, 32'h00000080);
        op(1, 32'h102, 2, 0, 32'h11223344);
        chk("sp_a0", c_a1, 30'h40); chk("sp_m0", c_m1, 4'hC); chk("sp_d0", c_d1[31:16], 16'h3344);
        chk("sp_a1", c_a2, 30'h41); chk("sp_m1", c_m2, 4'h3); chk("sp_d1", c_d2[15:0], 16'h1122);
        op(1, 32'h100, 2, 0, 32'hAB000000);
        op(1, 32'h104, 2, 0, 32'h000000CD);
        op(0, 32'h103, 1, 1, 0);
        chk("lh_split", c_rd, 32'hFFFFCDAB);
        op(1, 32'hFFFFFFFE, 2, 0, 32'hCAFEF00D);
        chk("wrap_a0", c_a1, 30'h3FFFFFFF); chk("wrap_a1", c_a2, 30'h0);
        op(0, 32'hFFFFFFFE, 2, 0, 0);

        for (int t = 0; t < 300; t++) begin
            a = ($urandom_range(0, 1) == 0) ? 32'h100 + $urandom_range(0, 63)
                                            : 32'hFFFFFFF0 + $urandom_range(0, 31);
            op($urandom_range(0, 1) == 1, a, 2'($urandom_range(0, 3)),
               $urandom_range(0, 1) == 1, $urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
        end

        // Reset during ACC1 of a split store.
        req_valid = 1; req_write = 1; req_addr = 32'h102; req_size = 2; req_data = 32'h55667788;
        @(posedge clock); @(negedge clock);
        req_valid = 0;
        @(negedge clock);
        reset = 1;
        @(posedge clock); @(negedge clock);
        chk("rst1_mask", bus_mask_w, 0);
        chk("rst1_rvalid", resp_valid, 0);
        chk("rst1_ready", req_ready, 1);
        reset = 0;
        repeat (3) begin @(negedge clock); chk("rst1_quiet", resp_valid, 0); end

        // ALLOW_SPLIT = 0: split refused at T+1, aligned store still runs.
        n_req_valid = 1; n_req_write = 1; n_req_addr = 32'h101; n_req_size = 2; n_req_data = 32'h12345678;
        @(posedge clock); @(negedge clock);
        n_req_valid = 0;
        chk("ns_rvalid", n_resp_valid, 1); chk("ns_rerr", n_resp_error, 1);
        chk("ns_rdata", n_resp_data, 0); chk("ns_mask", n_bus_mask_w, 0); chk("ns_ready", n_req_ready, 1);
        @(negedge clock);
        chk("ns_pulse", n_resp_valid, 0); chk("ns_mask2", n_bus_mask_w, 0);
        n_req_valid = 1; n_req_addr = 32'h100;
        @(posedge clock); @(negedge clock);
        n_req_valid = 0;
        chk("ns_al_mask", n_bus_mask_w, 4'hF); chk("ns_al_rv1", n_resp_valid, 0);
        @(negedge clock);
        chk("ns_al_rv2", n_resp_valid, 1); chk("ns_al_err", n_resp_error, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
